// File: rtl/mem_access_unit.sv
// Load/store initiator between the execute stage and a word-addressed data memory.
// Sub-word stores use read-modify-write. Misaligned or reserved-size requests are rejected without any memory access.
module mem_access_unit (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        wr_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic [29:0] ad_o,
  output logic [31:0] wrdata_o,
  output logic        memwr_o,
  input  logic [31:0] dm_i
);

  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, FIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] wrdata_q, wrdata_d;
  logic        err_q, err_d;

  logic        badReq;
  logic [4:0]  laneShift;
  logic [31:0] shifted;
  logic [7:0]  byteVal;
  logic [15:0] halfVal;
  logic [31:0] loadVal;
  logic [31:0] mergedVal;

  assign badReq = (size_i == 2'b11)
               || (size_i == 2'b01 && addr_i[0])
               || (size_i == 2'b10 && addr_i[1:0] != 2'b00);

  // Lane extraction and merge both work on the word returned in MERGE.
  always_comb begin
    laneShift = {addr_q[1:0], 3'b000};
    shifted   = dm_i >> laneShift;
    byteVal   = shifted[7:0];
    halfVal   = addr_q[1] ? dm_i[31:16] : dm_i[15:0];
    case (size_q)
      2'b00:   loadVal = {{24{sign_q & byteVal[7]}}, byteVal};
      2'b01:   loadVal = {{16{sign_q & halfVal[15]}}, halfVal};
      default: loadVal = dm_i;
    endcase
    mergedVal = dm_i;
    if (size_q == 2'b00) begin
      mergedVal[laneShift +: 8] = wdata_q[7:0];
    end else if (addr_q[1]) begin
      mergedVal[31:16] = wdata_q[15:0];
    end else begin
      mergedVal[15:0] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wr_d     = wr_q;
    size_d   = size_q;
    sign_d   = sign_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    wrdata_d = wrdata_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          addr_d  = addr_i;
          wr_d    = wr_i;
          size_d  = size_i;
          sign_d  = sign_i;
          wdata_d = wdata_i;
          if (badReq) begin
            state_d = FIN;
            err_d   = 1'b1;
          end else if (wr_i && size_i == 2'b10) begin
            state_d  = WRITE;
            wrdata_d = wdata_i;
          end else begin
            state_d = READ;
          end
        end
      end
      READ:  state_d = MERGE;
      MERGE: begin
        if (wr_q) begin
          wrdata_d = mergedVal;
          state_d  = WRITE;
        end else begin
          rdata_d = loadVal;
          state_d = FIN;
        end
      end
      WRITE:   state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      size_q   <= 2'b00;
      sign_q   <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      wrdata_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      size_q   <= size_d;
      sign_q   <= sign_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      wrdata_q <= wrdata_d;
      err_q    <= err_d;
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign memwr_o  = (state_q == WRITE);
  assign done_o   = (state_q == FIN);
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;
  assign ad_o     = addr_q[31:2];
  assign wrdata_o = wrdata_q;

endmodule
